// File: rtl/mac_engine_nlane.sv
// N-lane signed MAC engine with iteration counter, rounding, saturation
// and full output backpressure behind a shared valid/ready handshake.
module mac_engine_nlane #(
    parameter int NB_LANES   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_LEN    = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           start_i,
    input  logic                           simple_mul_i,
    input  logic [4:0]                     shift_i,
    input  logic                           round_i,
    input  logic                           sat_i,
    input  logic [$clog2(CNT_LEN):0]       len_i,
    input  logic [15:0]                    nb_iter_i,
    input  logic                           a_valid_i,
    output logic                           a_ready_o,
    input  logic [NB_LANES*DATA_WIDTH-1:0] a_data_i,
    input  logic                           b_valid_i,
    output logic                           b_ready_o,
    input  logic [NB_LANES*DATA_WIDTH-1:0] b_data_i,
    input  logic                           c_valid_i,
    output logic                           c_ready_o,
    input  logic [NB_LANES*DATA_WIDTH-1:0] c_data_i,
    output logic                           d_valid_o,
    input  logic                           d_ready_i,
    output logic [NB_LANES*DATA_WIDTH-1:0] d_data_o,
    output logic                           busy_o,
    output logic [$clog2(CNT_LEN):0]       cnt_o,
    output logic [15:0]                    iter_o,
    output logic                           done_o
);

    localparam int CW        = $clog2(CNT_LEN) + 1;
    localparam int PW        = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(CNT_LEN);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]    state_q;
    logic          simple_q;
    logic          round_q;
    logic          sat_q;
    logic [4:0]    shift_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   nb_iter_q;
    logic [15:0]   red_q;
    logic [15:0]   iter_q;

    logic s1_valid;
    logic s1_first;
    logic s1_emit;
    logic s1_red_end;
    logic s1_job_end;
    logic d_valid_q;
    logic d_red_end_q;
    logic d_job_end_q;
    logic done_q;

    logic advance;
    logic red_end;
    logic need_c;
    logic job_end;
    logic base;
    logic accept;
    logic d_fire;
    logic [ACC_WIDTH:0] rnd;

    assign advance = !(d_valid_q && !d_ready_i);
    assign red_end = (cnt_q == len_q - CW'(1));
    assign need_c  = simple_q || red_end;
    assign job_end = red_end && (red_q == nb_iter_q - 16'd1);
    assign base    = (state_q == COMPUTE) && advance
                   && (!need_c || c_valid_i);
    assign accept  = base && a_valid_i && b_valid_i;
    assign d_fire  = d_valid_q && d_ready_i;

    assign a_ready_o = base && b_valid_i;
    assign b_ready_o = base && a_valid_i;
    assign c_ready_o = base && a_valid_i && b_valid_i && need_c;

    assign d_valid_o = d_valid_q;
    assign busy_o    = (state_q != IDLE);
    assign cnt_o     = cnt_q;
    assign iter_o    = iter_q;
    assign done_o    = done_q;

    // half-LSB rounding constant, zero when no shift is applied
    always_comb begin
        rnd = '0;
        if (round_q && shift_q != 5'd0)
            rnd = {{ACC_WIDTH{1'b0}}, 1'b1} << (shift_q - 5'd1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            simple_q    <= 1'b0;
            round_q     <= 1'b0;
            sat_q       <= 1'b0;
            shift_q     <= '0;
            len_q       <= '0;
            nb_iter_q   <= '0;
            cnt_q       <= '0;
            red_q       <= '0;
            iter_q      <= '0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_emit     <= 1'b0;
            s1_red_end  <= 1'b0;
            s1_job_end  <= 1'b0;
            d_valid_q   <= 1'b0;
            d_red_end_q <= 1'b0;
            d_job_end_q <= 1'b0;
            done_q      <= 1'b0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            simple_q    <= 1'b0;
            round_q     <= 1'b0;
            sat_q       <= 1'b0;
            shift_q     <= '0;
            len_q       <= '0;
            nb_iter_q   <= '0;
            cnt_q       <= '0;
            red_q       <= '0;
            iter_q      <= '0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_emit     <= 1'b0;
            s1_red_end  <= 1'b0;
            s1_job_end  <= 1'b0;
            d_valid_q   <= 1'b0;
            d_red_end_q <= 1'b0;
            d_job_end_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (advance) begin
                s1_valid  <= accept;
                d_valid_q <= s1_valid && s1_emit;
                if (accept) begin
                    s1_first   <= simple_q || (cnt_q == '0);
                    s1_emit    <= need_c;
                    s1_red_end <= red_end;
                    s1_job_end <= job_end;
                end
                if (s1_valid && s1_emit) begin
                    d_red_end_q <= s1_red_end;
                    d_job_end_q <= s1_job_end;
                end
            end
            if (accept) begin
                if (red_end) begin
                    cnt_q <= '0;
                    red_q <= red_q + 16'd1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            if (d_fire && d_red_end_q)
                iter_q <= iter_q + 16'd1;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_i == '0 || nb_iter_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= COMPUTE;
                            simple_q  <= simple_mul_i;
                            round_q   <= round_i;
                            sat_q     <= sat_i;
                            shift_q   <= shift_i;
                            len_q     <= len_i;
                            nb_iter_q <= nb_iter_i;
                            cnt_q     <= '0;
                            red_q     <= '0;
                            iter_q    <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    if (accept && job_end)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (d_fire && d_job_end_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] a_k;
        logic signed [DATA_WIDTH-1:0] b_k;
        logic signed [PW-1:0]         prod_k;
        logic [PW-1:0]                s1_prod;
        logic [DATA_WIDTH-1:0]        s1_c;
        logic [ACC_WIDTH-1:0]         acc_q;
        logic [ACC_WIDTH-1:0]         acc_n;
        logic [DATA_WIDTH-1:0]        d_q;
        logic signed [ACC_WIDTH:0]    sum;
        logic signed [ACC_WIDTH:0]    shd;
        logic signed [ACC_WIDTH:0]    r;
        logic [DATA_WIDTH-1:0]        res;

        assign a_k    = a_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        assign b_k    = b_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        assign prod_k = a_k * b_k;

        always_comb begin
            acc_n = (s1_first ? '0 : acc_q)
                  + {{(ACC_WIDTH-PW){s1_prod[PW-1]}}, s1_prod};
            sum = $signed({acc_n[ACC_WIDTH-1], acc_n}) + $signed(rnd);
            shd = sum >>> shift_q;
            r   = shd + $signed({{(ACC_WIDTH+1-DATA_WIDTH){s1_c[DATA_WIDTH-1]}}, s1_c});
            if (!sat_q)
                res = r[DATA_WIDTH-1:0];
            else if (r > SAT_MAX)
                res = SAT_MAX[DATA_WIDTH-1:0];
            else if (r < SAT_MIN)
                res = SAT_MIN[DATA_WIDTH-1:0];
            else
                res = r[DATA_WIDTH-1:0];
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s1_prod <= '0;
                s1_c    <= '0;
                acc_q   <= '0;
                d_q     <= '0;
            end else if (clear_i) begin
                s1_prod <= '0;
                s1_c    <= '0;
                acc_q   <= '0;
                d_q     <= '0;
            end else begin
                if (accept) begin
                    s1_prod <= prod_k;
                    s1_c    <= c_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
                if (advance && s1_valid) begin
                    acc_q <= acc_n;
                    if (s1_emit)
                        d_q <= res;
                end
            end
        end

        assign d_data_o[k*DATA_WIDTH +: DATA_WIDTH] = d_q;
    end

endmodule

// File: tb/tb_mac_engine_nlane.sv
// Directed bench for mac_engine_nlane: reset, simple/reduction modes,
// arithmetic edges, backpressure against a reference list, clear abort.
module tb_mac_engine_nlane;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int LW = NL * DW;
    localparam int CW = 11;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          start_i;
    logic          simple_mul_i;
    logic [4:0]    shift_i;
    logic          round_i;
    logic          sat_i;
    logic [CW-1:0] len_i;
    logic [15:0]   nb_iter_i;
    logic          a_valid_i, a_ready_o;
    logic          b_valid_i, b_ready_o;
    logic          c_valid_i, c_ready_o;
    logic [LW-1:0] a_data_i, b_data_i, c_data_i;
    logic          d_valid_o, d_ready_i;
    logic [LW-1:0] d_data_o;
    logic          busy_o;
    logic [CW-1:0] cnt_o;
    logic [15:0]   iter_o;
    logic          done_o;

    mac_engine_nlane #(
        .NB_LANES(NL), .DATA_WIDTH(DW), .CNT_LEN(1024)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .start_i(start_i), .simple_mul_i(simple_mul_i),
        .shift_i(shift_i), .round_i(round_i), .sat_i(sat_i),
        .len_i(len_i), .nb_iter_i(nb_iter_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
        .c_valid_i(c_valid_i), .c_ready_o(c_ready_o), .c_data_i(c_data_i),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_data_o(d_data_o),
        .busy_o(busy_o), .cnt_o(cnt_o), .iter_o(iter_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int c_fires = 0;
    int done_cnt = 0;
    logic [LW-1:0] dq[$];
    logic [LW-1:0] bp_exp[12];

    always @(posedge clk_i) begin
        if (d_valid_o && d_ready_i) dq.push_back(d_data_o);
        if (c_valid_i && c_ready_o) c_fires++;
        if (done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_all(input logic [31:0] a, b, c);
        a_data_i = {NL{a}};
        b_data_i = {NL{b}};
        c_data_i = {NL{c}};
    endtask

    task automatic start_job(input logic sm, input logic [4:0] sh,
                             input logic rd, input logic st,
                             input logic [CW-1:0] ln, input logic [15:0] ni);
        simple_mul_i = sm;
        shift_i = sh;
        round_i = rd;
        sat_i = st;
        len_i = ln;
        nb_iter_i = ni;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, output int n);
        n = 0;
        while (n < limit && !done_o) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, done_o, 1);
    endtask

    task automatic run_single(input logic [31:0] a, b, input logic [4:0] sh,
                              input logic rd, st, output logic [31:0] r);
        int n;
        set_all(a, b, 32'd0);
        dq.delete();
        start_job(1'b1, sh, rd, st, 11'd1, 16'd1);
        wait_done("single", 20, n);
        r = (dq.size() > 0) ? dq[0][31:0] : 32'hx;
    endtask

    initial begin
        int n;
        int d0;
        int c0;
        int idx;
        int stalls;
        logic stall_prev;
        logic acc_now;
        logic [LW-1:0] prev_d;
        logic [31:0] r;

        rst_ni = 1'b0;
        clear_i = 1'b0;
        start_i = 1'b0;
        simple_mul_i = 1'b0;
        shift_i = '0;
        round_i = 1'b0;
        sat_i = 1'b0;
        len_i = '0;
        nb_iter_i = '0;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        c_valid_i = 1'b0;
        d_ready_i = 1'b1;
        set_all(32'd0, 32'd0, 32'd0);
        repeat (3) tick();
        chk("rst_ctrl", {busy_o, done_o, d_valid_o, cnt_o, iter_o}, 0);
        chk("rst_data", d_data_o, 0);
        rst_ni = 1'b1;
        tick();

        // reset asserted in the middle of a running job
        set_all(32'd3, -32'sd4, 32'd5);
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        c_valid_i = 1'b1;
        start_job(1'b1, 5'd0, 1'b0, 1'b0, 11'd8, 16'd1);
        repeat (3) tick();
        chk("mid_dvalid", d_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_ctrl",
            {a_ready_o, b_ready_o, c_ready_o, busy_o, done_o, d_valid_o,
             cnt_o, iter_o}, 0);
        chk("mid_rst_data", d_data_o, 0);
        #1;
        rst_ni = 1'b1;
        tick();
        dq.delete();

        // len=0 start
        d0 = done_cnt;
        start_job(1'b0, 5'd0, 1'b0, 1'b0, 11'd0, 16'd1);
        chk("len0_done", done_o, 1);
        chk("len0_busy", busy_o, 0);
        chk("len0_ready", {a_ready_o, b_ready_o, c_ready_o}, 0);
        tick();
        chk("len0_done_low", done_o, 0);
        tick();
        chk("len0_pulses", done_cnt - d0, 1);

        // simple mode, 8 beats back to back
        set_all(32'd3, -32'sd4, 32'd5);
        dq.delete();
        start_job(1'b1, 5'd0, 1'b0, 1'b0, 11'd8, 16'd1);
        chk("sm_ready", a_ready_o, 1);
        tick();
        chk("sm_cnt1", cnt_o, 1);
        chk("sm_lat1", d_valid_o, 0);
        tick();
        chk("sm_lat2", d_valid_o, 1);
        chk("sm_data", d_data_o, {NL{32'hFFFF_FFF9}});
        wait_done("sm", 30, n);
        chk("sm_cycles", n, 8);
        chk("sm_busy", busy_o, 0);
        chk("sm_count", dq.size(), 8);
        for (int i = 0; i < dq.size(); i++)
            chk("sm_beat", dq[i], {NL{32'hFFFF_FFF9}});

        // reduction mode, len=4, nb_iter=2
        for (int k = 0; k < NL; k++) begin
            a_data_i[k*DW +: DW] = k + 1;
            b_data_i[k*DW +: DW] = k + 1;
            c_data_i[k*DW +: DW] = 10;
        end
        dq.delete();
        c0 = c_fires;
        start_job(1'b0, 5'd0, 1'b0, 1'b0, 11'd4, 16'd2);
        wait_done("red", 40, n);
        chk("red_count", dq.size(), 2);
        chk("red_d0", dq.size() > 0 ? dq[0] : 'x,
            {32'd74, 32'd46, 32'd26, 32'd14});
        chk("red_d1", dq.size() > 1 ? dq[1] : 'x,
            {32'd74, 32'd46, 32'd26, 32'd14});
        chk("red_iter", iter_o, 2);
        chk("red_cfires", c_fires - c0, 2);

        // arithmetic edges
        run_single(32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0, 1'b0, 1'b1, r);
        chk("sat_on", r, 32'h7FFF_FFFF);
        run_single(32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0, 1'b0, 1'b0, r);
        chk("sat_off", r, 32'h0000_0001);
        run_single(32'd3, 32'd1, 5'd1, 1'b1, 1'b0, r);
        chk("rnd_pos_on", r, 32'd2);
        run_single(32'd3, 32'd1, 5'd1, 1'b0, 1'b0, r);
        chk("rnd_pos_off", r, 32'd1);
        run_single(-32'sd3, 32'd1, 5'd1, 1'b1, 1'b0, r);
        chk("rnd_neg_on", r, 32'hFFFF_FFFF);
        run_single(-32'sd3, 32'd1, 5'd1, 1'b0, 1'b0, r);
        chk("rnd_neg_off", r, 32'hFFFF_FFFE);

        // backpressure with random valids and a 5-cycle d stall
        for (int i = 0; i < 12; i++)
            for (int k = 0; k < NL; k++)
                bp_exp[i][k*DW +: DW] =
                    (i*3 - 7 + k) * (5 - i + 2*k) + (i*11 - k);
        dq.delete();
        start_job(1'b1, 5'd0, 1'b0, 1'b0, 11'd12, 16'd1);
        idx = 0;
        stalls = 0;
        stall_prev = 1'b0;
        prev_d = '0;
        for (int cyc = 0; cyc < 300 && !done_o; cyc++) begin
            if (stall_prev) chk("bp_hold", d_data_o, prev_d);
            if (cyc >= 8 && cyc < 13) d_ready_i = 1'b0;
            else if (cyc < 8) d_ready_i = 1'b1;
            else d_ready_i = ($urandom_range(0, 3) != 0);
            if (idx < 12) begin
                a_valid_i = (cyc < 8) || ($urandom_range(0, 3) != 0);
                b_valid_i = (cyc < 8) || ($urandom_range(0, 3) != 0);
                c_valid_i = (cyc < 8) || ($urandom_range(0, 3) != 0);
                for (int k = 0; k < NL; k++) begin
                    a_data_i[k*DW +: DW] = idx*3 - 7 + k;
                    b_data_i[k*DW +: DW] = 5 - idx + 2*k;
                    c_data_i[k*DW +: DW] = idx*11 - k;
                end
            end else begin
                a_valid_i = 1'b0;
                b_valid_i = 1'b0;
                c_valid_i = 1'b0;
            end
            #1;
            stall_prev = d_valid_o && !d_ready_i;
            if (stall_prev) begin
                stalls++;
                chk("bp_rdy", {a_ready_o, b_ready_o, c_ready_o}, 0);
            end
            prev_d = d_data_o;
            acc_now = a_valid_i && a_ready_o;
            @(posedge clk_i);
            #1;
            if (acc_now) idx++;
        end
        chk("bp_done", done_o, 1);
        chk("bp_stalled", stalls >= 5, 1);
        chk("bp_count", dq.size(), 12);
        for (int i = 0; i < 12; i++)
            chk("bp_beat", i < dq.size() ? dq[i] : 'x, bp_exp[i]);
        d_ready_i = 1'b1;

        // clear at cnt=2 together with start
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        c_valid_i = 1'b1;
        set_all(32'd100, 32'd100, 32'd0);
        dq.delete();
        start_job(1'b0, 5'd0, 1'b0, 1'b0, 11'd4, 16'd1);
        n = 0;
        while (cnt_o != 11'd2 && n < 20) begin
            tick();
            n++;
        end
        chk("clr_cnt", cnt_o, 2);
        d0 = done_cnt;
        clear_i = 1'b1;
        start_i = 1'b1;
        len_i = 11'd2;
        set_all(32'd1, 32'd1, 32'd0);
        tick();
        clear_i = 1'b0;
        start_i = 1'b0;
        chk("clr_state", {busy_o, d_valid_o, cnt_o, iter_o}, 0);
        repeat (5) tick();
        chk("clr_nodone", done_cnt - d0, 0);
        chk("clr_noout", dq.size(), 0);
        start_job(1'b0, 5'd0, 1'b0, 1'b0, 11'd2, 16'd1);
        wait_done("clr_next", 20, n);
        chk("clr_next_count", dq.size(), 1);
        chk("clr_next_data", dq.size() > 0 ? dq[0] : 'x, {NL{32'd2}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_engine_nlane.md
# mac_engine_nlane

Parametrised multi-lane successor of the single-lane MAC datapath. It sits between the streamer (a/b/c sources, d sink) and the control FSM. NB_LANES independent signed MAC lanes share one handshake and one control word. Over the single-lane engine it adds:
- an in-engine iteration counter (`nb_iter`), so one start produces several reductions;
- optional round-to-nearest on the output shift;
- optional saturation;
- full output backpressure.

## Interface
Parameters:
- NB_LANES, 4, number of parallel MAC lanes
- DATA_WIDTH, 32, signed operand/result width per lane
- CNT_LEN, 1024, maximum beats per reduction; ACC_WIDTH = 2*DATA_WIDTH + $clog2(CNT_LEN) (localparam)

Ports:
- clk_i  in  1  clock; one clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous abort: FSM to IDLE, all registers zeroed
- start_i  in  1  one-cycle pulse; samples control inputs; ignored unless IDLE
- simple_mul_i  in  1  1: one d beat per input beat; 0: reduce len beats
- shift_i  in  5  arithmetic right shift applied to result
- round_i  in  1  add 2^(shift-1) before shift (no effect when shift=0)
- sat_i  in  1  1: clamp to signed DATA_WIDTH; 0: truncate low bits
- len_i  in  $clog2(CNT_LEN)+1  beats per reduction (1..CNT_LEN)
- nb_iter_i  in  16  reductions per start
- a_valid_i/a_ready_o, b_valid_i/b_ready_o, c_valid_i/c_ready_o  in/out  1  input handshakes
- a_data_i, b_data_i, c_data_i  in  NB_LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- d_valid_o/d_ready_i  out/in  1  output handshake
- d_data_o  out  NB_LANES*DATA_WIDTH  results, same lane packing
- busy_o  out  1  FSM not IDLE
- cnt_o  out  $clog2(CNT_LEN)+1  beats accepted in current reduction (counts from 1)
- iter_o  out  16  reductions completed
- done_o  out  1  one-cycle pulse at end of job

## Operation
- FSM: IDLE, COMPUTE, DRAIN.
  - IDLE→COMPUTE on start_i with len_i≠0 and nb_iter_i≠0.
  - With len_i=0 or nb_iter_i=0: stay IDLE and pulse done_o next cycle.
  - COMPUTE→DRAIN when the last beat of the last reduction is accepted.
  - DRAIN→IDLE on the final d handshake; done_o is high the following cycle.
- Control inputs are latched on start; later changes are ignored until IDLE.
- `advance` = !(d_valid_o && !d_ready_i).
- `need_c` = simple_mul or (cnt = len-1, i.e. last beat).
- Ready signals:
  - a_ready_o = b_ready_o = COMPUTE && advance && b_valid_i/a_valid_i cross-qualified && (!need_c || c_valid_i).
  - c_ready_o = same condition && need_c.
- A beat is accepted only when all required valids are high; no partial consumption.
- Stage 1 per lane: prod = a*b (signed, 2*DATA_WIDTH), registered with the beat's last/c tags.
- Stage 2 per lane:
  - acc = (first ? 0 : acc) + sext(prod), wrapping modulo ACC_WIDTH.
  - On the last beat (every beat in simple mode): r = ((acc + rnd) >>> shift) + sext(c), computed in ACC_WIDTH+1 bits.
  - Output is sat ? clamp(r, -2^(DW-1), 2^(DW-1)-1) : r[DW-1:0].
- cnt_o wraps to 0 after len beats; iter_o increments on each reduction's final d handshake.
- The accumulator resets on the first beat of each reduction; no carry between reductions.
- Reset values: all outputs 0; d_data_o 0; FSM IDLE.
- clear_i has priority over all events, including a same-cycle start_i and a same-cycle handshake. In-flight data is dropped and no done_o is issued.

## Timing
- Beat accepted at edge t → product registered at t → d_valid_o high after edge t+1 (2-cycle latency).
- Full throughput of 1 beat/cycle while d_ready_i=1.
- While d_valid_o && !d_ready_i:
  - d_data_o is held stable;
  - stage 1 holds;
  - a/b/c ready drop combinationally.
- No beat is lost or duplicated.
- done_o is asserted 1 cycle after the last d handshake, in the same cycle busy_o falls.
- start_i arriving in the done_o cycle is accepted.

## Test plan
- Reset/idle: assert rst_ni low mid-job → all outputs 0, busy_o=0. Apply start with len=0 → done_o pulses once, no ready asserted.
- Simple mode, shift=0, all lanes a=3, b=-4, c=5 → every lane d=-7, d_valid_o 2 cycles after accept. Stream 8 beats back-to-back at 1 beat/cycle.
- Reduction mode, len=4, nb_iter=2, lane k: a=b=k+1, c=10 → two d beats {14,26,46,74}. iter_o=2, done_o one cycle after second handshake, c consumed only twice.
- Arithmetic edges, simple mode:
  - a=b=0x7FFFFFFF: sat=1 → 0x7FFFFFFF; sat=0 → 0x00000001.
  - a=3, b=1, shift=1: round=1 → 2; round=0 → 1.
  - a=-3, b=1, shift=1: round=1 → -1; round=0 → -2.
- Backpressure: drive random valids and hold d_ready_i low 5 cycles mid-stream → ready drops, d_data_o stable, output sequence equals reference model, no loss/duplication.
- clear_i during COMPUTE at cnt=2, with start_i asserted in the same cycle → FSM IDLE, no done_o, next job's results uncontaminated by the old accumulator.
